// File: rtl/sr_latch_driver.sv
// Command stage for a gated NOR SR latch: synchronizes and debounces raw set/clear
// requests and issues bounded, non-overlapping S/R drive pulses with a gate enable.
module sr_latch_driver #(
   parameter int unsigned DEB_CYCLES   = 4,
   parameter int unsigned PULSE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic en,
   output logic busy,
   output logic q_exp,
   output logic conflict
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

   // Line index 0 carries set requests, index 1 carries clear requests.
   logic [1:0] req;
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] lvl_q, lvl_d;
   logic [1:0] ev_q, ev_d;
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];

   assign req = {clr_req, set_req};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= req;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      lvl_d = lvl_q;
      ev_d  = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            cnt_d[i] = '0;
            lvl_d[i] = sync2_q[i];
            ev_d[i]  = sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q    <= '0;
         ev_q     <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         lvl_q    <= lvl_d;
         ev_q     <= ev_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   state_e     state_q, state_d;
   logic       cmd_q, cmd_d;
   logic       pend_vld_q, pend_vld_d;
   logic       pend_cmd_q, pend_cmd_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic       q_exp_q, q_exp_d;
   logic       s_q, s_d, r_q, r_d, en_q, en_d, busy_q, busy_d;
   logic       conflict_q, conflict_d;
   logic       single_ev;

   assign single_ev = ev_q[0] ^ ev_q[1];

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      pend_vld_d = pend_vld_q;
      pend_cmd_d = pend_cmd_q;
      pcnt_d     = pcnt_q;
      q_exp_d    = q_exp_q;
      conflict_d = ev_q[0] & ev_q[1];

      unique case (state_q)
         IDLE: begin
            // A fresh event is newer than anything pending, so it wins.
            if (single_ev) begin
               state_d    = DRIVE;
               cmd_d      = ev_q[0];
               pend_vld_d = 1'b0;
               pcnt_d     = '0;
            end else if (pend_vld_q) begin
               state_d    = DRIVE;
               cmd_d      = pend_cmd_q;
               pend_vld_d = 1'b0;
               pcnt_d     = '0;
            end
         end
         DRIVE: begin
            if (single_ev) begin
               pend_vld_d = 1'b1;
               pend_cmd_d = ev_q[0];
            end
            if (pcnt_q == PULSE_LAST) begin
               state_d = RELEASE;
               q_exp_d = cmd_q;
            end else begin
               pcnt_d = pcnt_q + 8'd1;
            end
         end
         RELEASE: begin
            if (single_ev) begin
               pend_vld_d = 1'b1;
               pend_cmd_d = ev_q[0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so the latch sees clean levels.
      en_d   = (state_d == DRIVE);
      busy_d = (state_d != IDLE);
      s_d    = busy_d & cmd_d;
      r_d    = busy_d & ~cmd_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cmd_q      <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_cmd_q <= 1'b0;
         pcnt_q     <= '0;
         q_exp_q    <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         pend_vld_q <= pend_vld_d;
         pend_cmd_q <= pend_cmd_d;
         pcnt_q     <= pcnt_d;
         q_exp_q    <= q_exp_d;
         s_q        <= s_d;
         r_q        <= r_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign en       = en_q;
   assign busy     = busy_q;
   assign q_exp    = q_exp_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed and random request patterns checked each cycle
// against a timeline model built from sample-window debounce and drive-slot scheduling.
module tb_sr_latch_driver;

   localparam int DEB = 4;
   localparam int PUL = 2;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_req = 1'b0;
   logic clr_req = 1'b0;
   logic s, r, en, busy, q_exp, conflict;

   int errors = 0;
   int checks = 0;

   sr_latch_driver #(
      .DEB_CYCLES   (DEB),
      .PULSE_CYCLES (PUL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .s        (s),
      .r        (r),
      .en       (en),
      .busy     (busy),
      .q_exp    (q_exp),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   // Reference model state: raw sample history, debounced levels, drive slot timeline.
   logic hs [HMAX];
   logic hc [HMAX];
   int   e = 0;
   int   base = 0;
   logic ls = 1'b0, lc = 1'b0;
   logic pes = 1'b0, pec = 1'b0;
   int   st = -100;
   logic cmd = 1'b0;
   logic pv = 1'b0, pc = 1'b0;
   logic qm = 1'b0;
   logic exp_conf = 1'b0;

   function automatic logic raw_at(input logic sel, input int idx);
      if (idx < base) return 1'b0;
      return sel ? hc[idx] : hs[idx];
   endfunction

   // Level flips when the last DEB synchronized samples all disagree with it.
   function automatic logic flips(input logic sel, input logic cur);
      for (int j = 0; j < DEB; j++)
         if (raw_at(sel, e - 2 - j) == cur) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      base = e;
      ls = 1'b0; lc = 1'b0;
      pes = 1'b0; pec = 1'b0;
      st = -100;
      pv = 1'b0;
      qm = 1'b0;
      exp_conf = 1'b0;
   endtask

   task automatic model_step();
      logic fs, fc, evs, evc;
      hs[e] = set_req;
      hc[e] = clr_req;
      fs = flips(1'b0, ls);
      fc = flips(1'b1, lc);
      evs = fs & ~ls;
      evc = fc & ~lc;
      if (fs) ls = ~ls;
      if (fc) lc = ~lc;
      exp_conf = pes & pec;
      if (pes ^ pec) begin
         if (e >= st + PUL + 2) begin
            st = e; cmd = pes; pv = 1'b0;
         end else begin
            pv = 1'b1; pc = pes;
         end
      end else if (pv && e >= st + PUL + 2) begin
         st = e; cmd = pc; pv = 1'b0;
      end
      if (e == st + PUL) qm = cmd;
      pes = evs;
      pec = evc;
      e++;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e - 1, obs, exp);
      end
   endtask

   task automatic check_all();
      int t;
      logic dr, rel;
      t = e - 1;
      dr  = (t >= st) && (t < st + PUL);
      rel = (t == st + PUL);
      chk("en", en, dr);
      chk("busy", busy, dr | rel);
      chk("s", s, (dr | rel) & cmd);
      chk("r", r, (dr | rel) & ~cmd);
      chk("q_exp", q_exp, qm);
      chk("conflict", conflict, exp_conf);
      chk("s_r_excl", s & r, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s"}, s, 1'b0);
      chk({tag, "_r"}, r, 1'b0);
      chk({tag, "_en"}, en, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_q_exp"}, q_exp, 1'b0);
      chk({tag, "_conflict"}, conflict, 1'b0);
   endtask

   task automatic run(input logic sv, input logic cv, input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(negedge clk);
         set_req = sv;
         clr_req = cv;
         @(posedge clk);
         model_step();
         #1 check_all();
      end
   endtask

   initial begin
      int unsigned sel;
      #3 check_zero("reset_init");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(1'b0, 1'b0, 6);

      // Single set request.
      run(1'b1, 1'b0, 10);
      run(1'b0, 1'b0, 12);
      chk("set_q_exp_const", q_exp, 1'b1);

      // Glitch shorter than the debounce window.
      run(1'b1, 1'b0, 3);
      run(1'b0, 1'b0, 12);
      chk("glitch_busy_const", busy, 1'b0);

      // Coincident set and clear.
      run(1'b1, 1'b1, 10);
      run(1'b0, 1'b0, 12);
      chk("coinc_q_exp_const", q_exp, 1'b1);

      // Clear queued behind a redundant set.
      run(1'b1, 1'b0, 2);
      run(1'b1, 1'b1, 10);
      run(1'b0, 1'b0, 15);
      chk("queued_q_exp_const", q_exp, 1'b0);

      // Completed set, then reset in the middle of the next drive.
      run(1'b1, 1'b0, 10);
      run(1'b0, 1'b0, 12);
      run(1'b1, 1'b0, 7);
      chk("pre_reset_en", en, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_zero("reset_mid_drive");
      model_reset();
      @(negedge clk);
      set_req = 1'b0;
      @(posedge clk);
      #1 check_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 1'b1, 10);
      run(1'b0, 1'b0, 12);

      // Randomized request segments.
      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      run(1'b1, 1'b0, $urandom_range(1, 10));
         else if (sel < 7) run(1'b0, 1'b1, $urandom_range(1, 10));
         else if (sel < 8) run(1'b1, 1'b1, $urandom_range(1, 10));
         else              run(1'b0, 1'b0, $urandom_range(1, 10));
      end
      run(1'b0, 1'b0, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
